// File: rtl/fmap_capture_drain.sv
// Captures one feature map per channel, then replays all maps as a
// channel-major valid/ready stream once every channel is full.
module fmap_capture_drain #(
    parameter int NUM_CH    = 6,
    parameter int DATA_W    = 8,
    parameter int MAP_COUNT = 196
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_pixel,
    output logic [$clog2(NUM_CH)-1:0]  out_chan,
    output logic                       out_last,
    output logic                       capture_done,
    output logic                       drain_done,
    output logic                       overflow
);

    localparam int CNT_W  = $clog2(MAP_COUNT + 1);
    localparam int TOTAL  = NUM_CH * MAP_COUNT;
    localparam int WORD_W = $clog2(TOTAL);
    localparam int CH_W   = $clog2(NUM_CH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(MAP_COUNT);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(MAP_COUNT - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(TOTAL - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  wr_cnt [NUM_CH];
    logic [NUM_CH-1:0] we;
    logic [NUM_CH-1:0] is_full;
    logic [NUM_CH-1:0] full_next;
    logic [NUM_CH-1:0] hit_full;

    logic [CH_W-1:0]   rd_ch;
    logic [CNT_W-1:0]  rd_idx;
    logic [WORD_W-1:0] rd_word;
    logic [CH_W-1:0]   nxt_ch;
    logic [CNT_W-1:0]  nxt_idx;
    logic [CNT_W-1:0]  rd_sel_idx;
    logic              valid_q;
    logic              fire;
    logic              at_last;
    logic [DATA_W-1:0] rd_bus [NUM_CH];

    always_comb begin
        we        = '0;
        is_full   = '0;
        full_next = '0;
        hit_full  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            is_full[c]   = (wr_cnt[c] == FULL);
            we[c]        = (state == S_CAPTURE) && !start
                           && in_valid[c] && !is_full[c];
            full_next[c] = is_full[c]
                           || (we[c] && (wr_cnt[c] == LAST_IDX));
            hit_full[c]  = (state != S_IDLE) && !start
                           && in_valid[c] && is_full[c];
        end
    end

    // Read address looks one word ahead on a transfer so the buffer
    // output always matches the word being presented: no bubbles.
    always_comb begin
        fire       = valid_q && out_ready;
        at_last    = (rd_word == LAST_WORD);
        nxt_idx    = (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
        nxt_ch     = (rd_idx == LAST_IDX) ? rd_ch + 1'b1 : rd_ch;
        rd_sel_idx = fire ? nxt_idx : rd_idx;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [MAP_COUNT];
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk) begin
            if (we[c]) begin
                mem[wr_cnt[c]] <= in_pixel[c*DATA_W +: DATA_W];
            end
            q <= mem[rd_sel_idx];
        end

        assign rd_bus[c] = q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rd_ch        <= '0;
            rd_idx       <= '0;
            rd_word      <= '0;
            valid_q      <= 1'b0;
            capture_done <= 1'b0;
            drain_done   <= 1'b0;
            overflow     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_cnt[c] <= '0;
            end
        end else if (start) begin
            state        <= S_CAPTURE;
            rd_ch        <= '0;
            rd_idx       <= '0;
            rd_word      <= '0;
            valid_q      <= 1'b0;
            capture_done <= 1'b0;
            drain_done   <= 1'b0;
            overflow     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (we[c]) begin
                    wr_cnt[c] <= wr_cnt[c] + 1'b1;
                end
            end
            if (|hit_full) begin
                overflow <= 1'b1;
            end
            unique case (state)
                S_CAPTURE: begin
                    if (&full_next) begin
                        state        <= S_DRAIN;
                        capture_done <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (fire) begin
                        if (at_last) begin
                            valid_q    <= 1'b0;
                            drain_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            rd_idx  <= nxt_idx;
                            rd_ch   <= nxt_ch;
                            rd_word <= rd_word + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                end
                S_DONE: begin
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_pixel = valid_q ? rd_bus[rd_ch] : '0;
    assign out_chan  = valid_q ? rd_ch : '0;
    assign out_last  = valid_q && at_last;

endmodule

// File: tb/tb_fmap_capture_drain.sv
// Directed bench for fmap_capture_drain: fill patterns, drain order,
// backpressure, overflow, restart and asynchronous reset.
module tb_fmap_capture_drain;

    localparam int NUM_CH    = 6;
    localparam int DATA_W    = 8;
    localparam int MAP_COUNT = 196;
    localparam int TOTAL     = NUM_CH * MAP_COUNT;
    localparam int CH_W      = $clog2(NUM_CH);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH*DATA_W-1:0] in_pixel = '0;
    logic                     out_ready = 1'b0;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_pixel;
    logic [CH_W-1:0]          out_chan;
    logic                     out_last;
    logic                     capture_done;
    logic                     drain_done;
    logic                     overflow;

    logic [DATA_W-1:0] exp_mem [NUM_CH][MAP_COUNT];
    int errors = 0;
    int checks = 0;
    int ncyc;

    always #5 clk = ~clk;

    fmap_capture_drain #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .MAP_COUNT(MAP_COUNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_pixel(in_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
        .out_chan(out_chan),
        .out_last(out_last),
        .capture_done(capture_done),
        .drain_done(drain_done),
        .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("st_valid", 32'(out_valid), 0);
        check("st_cap", 32'(capture_done), 0);
        check("st_drain", 32'(drain_done), 0);
        check("st_ovf", 32'(overflow), 0);
    endtask

    // mode 0 lockstep, 1 ch5 late + ch2 gapped, 2 ch0 overflows
    task automatic fill(input int mode, input int dsel);
        int sent [NUM_CH];
        int quota [NUM_CH];
        int delay [NUM_CH];
        int cyc;
        bit busy;
        logic [DATA_W-1:0] p;
        for (int c = 0; c < NUM_CH; c++) begin
            sent[c]  = 0;
            quota[c] = MAP_COUNT;
            delay[c] = 0;
        end
        if (mode == 1) delay[5] = 50;
        if (mode == 2) begin
            quota[0] = MAP_COUNT + 1;
            delay[1] = 5;
        end
        cyc  = 0;
        busy = 1'b1;
        while (busy && cyc < 2000) begin
            in_valid = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (sent[c] < quota[c] && cyc >= delay[c]
                    && !(mode == 1 && c == 2
                         && $urandom_range(0, 99) < 30)) begin
                    if (sent[c] < MAP_COUNT) begin
                        p = (dsel == 0) ? 8'((c*37 + sent[c]) % 256)
                                        : 8'($urandom);
                        exp_mem[c][sent[c]] = p;
                    end else begin
                        p = 8'h7F;
                    end
                    in_valid[c] = 1'b1;
                    in_pixel[c*DATA_W +: DATA_W] = p;
                    sent[c]++;
                end
            end
            check("cap_early", 32'(capture_done), 0);
            tick();
            cyc++;
            busy = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (sent[c] < quota[c]) busy = 1'b1;
            end
        end
        in_valid = '0;
        check("fill_time", 32'(busy), 0);
        check("cap_done", 32'(capture_done), 1);
        check("valid_n1", 32'(out_valid), 0);
        check("ovf", 32'(overflow), 32'(mode == 2));
    endtask

    // pattern 0: ready held high; pattern 1: ready toggles 1,0,1,0
    task automatic drain_check(input int pattern, input int n,
                               output int cycles);
        int w = 0;
        int cyc = 0;
        bit hold = 1'b0;
        logic [DATA_W-1:0] hp;
        logic [CH_W-1:0] hc;
        logic hl;
        while (w < n && cyc < 10000) begin
            out_ready = (pattern == 0) ? 1'b1 : (cyc % 2 == 0);
            if (hold) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_pix", 32'(out_pixel), 32'(hp));
                check("hold_chan", 32'(out_chan), 32'(hc));
                check("hold_last", 32'(out_last), 32'(hl));
            end
            hold = 1'b0;
            if (out_valid && out_ready) begin
                check("pix", 32'(out_pixel),
                      32'(exp_mem[w / MAP_COUNT][w % MAP_COUNT]));
                check("chan", 32'(out_chan), 32'(w / MAP_COUNT));
                check("last", 32'(out_last), 32'(w == TOTAL - 1));
                w++;
            end else if (out_valid) begin
                hold = 1'b1;
                hp = out_pixel;
                hc = out_chan;
                hl = out_last;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_count", 32'(w), 32'(n));
        cycles = cyc;
    endtask

    task automatic frame_body(input int mode, input int dsel,
                              input int pattern);
        int cyc;
        fill(mode, dsel);
        tick();
        check("valid_n2", 32'(out_valid), 1);
        check("cap_hold", 32'(capture_done), 1);
        drain_check(pattern, TOTAL, cyc);
        if (pattern == 0) check("no_bubble", 32'(cyc), 32'(TOTAL));
        check("end_valid", 32'(out_valid), 0);
        check("end_last", 32'(out_last), 0);
        check("drain_done", 32'(drain_done), 1);
        tick();
        check("done_valid", 32'(out_valid), 0);
        check("done_hold", 32'(drain_done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_pix", 32'(out_pixel), 0);
        check("rst_cap", 32'(capture_done), 0);
        check("rst_drain", 32'(drain_done), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // lockstep fill, no backpressure
        do_start();
        frame_body(0, 0, 0);

        // same fill under alternating backpressure
        do_start();
        frame_body(0, 0, 1);

        // skewed and gapped channels
        do_start();
        frame_body(1, 1, 0);

        // ch0 sends one pixel too many
        do_start();
        frame_body(2, 1, 0);

        // restart mid-drain, with in_valid ignored in the start cycle
        do_start();
        fill(0, 1);
        tick();
        in_valid = 6'b001000;
        tick();
        in_valid = '0;
        check("ovf_drain", 32'(overflow), 1);
        drain_check(0, 300, ncyc);
        check("mid_valid", 32'(out_valid), 1);
        start = 1'b1;
        out_ready = 1'b1;
        in_valid = '1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        in_valid = '0;
        check("rs_valid", 32'(out_valid), 0);
        check("rs_last", 32'(out_last), 0);
        check("rs_cap", 32'(capture_done), 0);
        check("rs_drain", 32'(drain_done), 0);
        check("rs_ovf", 32'(overflow), 0);
        frame_body(0, 1, 0);

        // asynchronous reset in the middle of a drain
        do_start();
        fill(0, 1);
        tick();
        drain_check(1, 100, ncyc);
        in_valid = 6'b000001;
        tick();
        in_valid = '0;
        check("ovf_set", 32'(overflow), 1);
        check("pre_valid", 32'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 0);
        check("ar_pix", 32'(out_pixel), 0);
        check("ar_chan", 32'(out_chan), 0);
        check("ar_last", 32'(out_last), 0);
        check("ar_cap", 32'(capture_done), 0);
        check("ar_drain", 32'(drain_done), 0);
        check("ar_ovf", 32'(overflow), 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 1) ? '1 : '0;
            tick();
            check("idle_valid", 32'(out_valid), 0);
            check("idle_cap", 32'(capture_done), 0);
        end
        in_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
